// File: rtl/picosoc_pkg.sv
// rtl/picosoc_pkg.sv - shared FSM encoding and default constants for the IO bus
package picosoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } iobus_state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA   = 32'hDEAD_BEEF;
    localparam logic [7:0]  DEFAULT_FIRST_PAGE = 8'h03;
    localparam int          SEL_W              = 3;

endpackage

// File: rtl/picosoc_iobus_timer.sv
// rtl/picosoc_iobus_timer.sv - loadable down-counter with zero flag for slave timeouts
module picosoc_iobus_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/picosoc_iobus.sv
// rtl/picosoc_iobus.sv - page-decoded IO bus bridge with timeout and sticky error capture
module picosoc_iobus
    import picosoc_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [7:0]  FIRST_PAGE = DEFAULT_FIRST_PAGE,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    output logic [NUM_SLAVES-1:0]   s_valid,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    input  logic [NUM_SLAVES-1:0]   s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                    err_flag,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    iobus_state_e     state_q, state_d;
    logic [31:0]      s_addr_q, s_addr_d;
    logic [31:0]      s_wdata_q, s_wdata_d;
    logic [3:0]       s_wstrb_q, s_wstrb_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic             err_flag_q, err_flag_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic [7:0]       page;
    logic [7:0]       rel;
    logic             page_hit;
    logic             sel_ready;
    logic [31:0]      sel_rdata;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             err_set;
    logic [31:0]      err_src;

    picosoc_iobus_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (CW'(TIMEOUT)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign page     = mem_addr[31:24];
    assign rel      = page - FIRST_PAGE;
    assign page_hit = (page >= FIRST_PAGE) && (rel < 8'(NUM_SLAVES));

    // Slave strobe and read/ready mux driven from the registered slave index.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_valid   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready  = s_ready[i];
                sel_rdata  = s_rdata[32*i +: 32];
                s_valid[i] = (state_q == ST_WAIT);
            end
        end
    end

    // Transaction FSM: decode in IDLE, wait for slave or timeout, one-cycle response.
    always_comb begin
        state_d     = state_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_wstrb_d   = s_wstrb_q;
        sel_d       = sel_q;
        mem_rdata_d = mem_rdata_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        err_set     = 1'b0;
        err_src     = mem_addr;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (page_hit) begin
                        s_addr_d  = mem_addr;
                        s_wdata_d = mem_wdata;
                        s_wstrb_d = mem_wstrb;
                        sel_d     = rel[SEL_W-1:0];
                        tmr_load  = 1'b1;
                        state_d   = ST_WAIT;
                    end else begin
                        mem_rdata_d = ERR_DATA;
                        err_set     = 1'b1;
                        err_src     = mem_addr;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (sel_ready) begin
                    mem_rdata_d = sel_rdata;
                    state_d     = ST_RESP;
                end else if (tmr_zero) begin
                    mem_rdata_d = ERR_DATA;
                    err_set     = 1'b1;
                    err_src     = s_addr_q;
                    state_d     = ST_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error: first error latches its address; a clear racing a new error keeps the flag and takes the new address.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (err_set) begin
            err_flag_d = 1'b1;
            if (!err_flag_q || err_clr) begin
                err_addr_d = err_src;
            end
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            sel_q       <= '0;
            mem_rdata_q <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            sel_q       <= sel_d;
            mem_rdata_q <= mem_rdata_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign mem_ready = (state_q == ST_RESP);
    assign mem_rdata = mem_rdata_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign err_flag  = err_flag_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_picosoc_iobus.sv
// tb/tb_picosoc_iobus.sv - directed self-checking bench for picosoc_iobus
module tb_picosoc_iobus;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            mem_valid;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic [NS-1:0]   s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [NS-1:0]   s_ready;
    logic [32*NS-1:0] s_rdata;
    logic            err_flag;
    logic [31:0]     err_addr;
    logic            err_clr;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    int          lat;
    int          widx;
    logic [NS-1:0] sv;
    logic [31:0] sa;
    logic [31:0] swd;
    logic [3:0]  sw;

    picosoc_iobus #(
        .NUM_SLAVES (NS),
        .FIRST_PAGE (8'h03),
        .TIMEOUT    (4),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // One request from the CPU side with a slave model answering after `delay` WAIT cycles (-1 = never).
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int delay, input bit noise, input bit clr);
        bit done;
        done = 1'b0;
        widx = 0; lat = 0; sv = '0; sa = '0; sw = '0; swd = '0; rd = '0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; err_clr = clr;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            err_clr = 1'b0;
            if (mem_ready) begin
                rd = mem_rdata; lat++; done = 1'b1; mem_valid = 1'b0; s_ready = '0;
            end else if (s_valid != '0) begin
                if (widx == 0) begin
                    sv = s_valid; sa = s_addr; sw = s_wstrb; swd = s_wdata;
                end
                s_ready = ((widx == delay) ? s_valid : '0) | (noise ? ~s_valid : '0);
                widx++;
            end else begin
                s_ready = '0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_no_ready got none want mem_ready within 40 cycles addr=%h", addr);
            mem_valid = 1'b0; s_ready = '0; err_clr = 1'b0;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        s_ready = '0; err_clr = 1'b0;
        s_rdata = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'h1234_5678, 32'hA0A0_0000};
        #12;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
        checks++; if (s_valid !== 4'b0) begin errors++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); end
        checks++; if ({err_flag, err_addr} !== 33'h0) begin errors++; $display("FAIL reset_err got %b/%h want 0/0", err_flag, err_addr); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_hit;
        do_xfer(32'h0400_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata got %h want 12345678", rd); end
        checks++; if (sv !== 4'b0010) begin errors++; $display("FAIL read_s_valid got %b want 0010", sv); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL read_err_flag got %b want 0", err_flag); end
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL read_single_pulse got %b want 0", mem_ready); end
    endtask

    task automatic test_write;
        do_xfer(32'h0300_0010, 32'hCAFE_F00D, 4'b0011, 3, 1'b0, 1'b0);
        checks++; if (sw !== 4'b0011) begin errors++; $display("FAIL write_s_wstrb got %b want 0011", sw); end
        checks++; if (sa !== 32'h0300_0010) begin errors++; $display("FAIL write_s_addr got %h want 03000010", sa); end
        checks++; if (swd !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_s_wdata got %h want cafef00d", swd); end
        checks++; if (sv !== 4'b0001) begin errors++; $display("FAIL write_s_valid got %b want 0001", sv); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL write_latency got %0d want 6", lat); end
        checks++; if (rd !== 32'hA0A0_0000) begin errors++; $display("FAIL write_rdata got %h want a0a00000", rd); end
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL write_single_pulse got %b want 0", mem_ready); end
    endtask

    task automatic test_exact_zero;
        do_xfer(32'h0600_0004, 32'h0, 4'b0000, 4, 1'b0, 1'b0);
        checks++; if (rd !== 32'hD3D3_D3D3) begin errors++; $display("FAIL zero_race_rdata got %h want d3d3d3d3", rd); end
        checks++; if (widx !== 5) begin errors++; $display("FAIL zero_race_wait_cycles got %0d want 5", widx); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL zero_race_err_flag got %b want 0", err_flag); end
        @(negedge clk);
    endtask

    task automatic test_miss;
        do_xfer(32'h0A00_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL miss_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_rdata got %h want deadbeef", rd); end
        checks++; if (widx !== 0) begin errors++; $display("FAIL miss_s_valid_cycles got %0d want 0", widx); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL miss_err_flag got %b want 1", err_flag); end
        checks++; if (err_addr !== 32'h0A00_0000) begin errors++; $display("FAIL miss_err_addr got %h want 0a000000", err_addr); end
        do_xfer(32'h0700_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_above_rdata got %h want deadbeef", rd); end
        do_xfer(32'h0200_0000, 32'h0, 4'b1111, 0, 1'b0, 1'b0);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_below_rdata got %h want deadbeef", rd); end
        checks++; if (err_addr !== 32'h0A00_0000) begin errors++; $display("FAIL miss_sticky_addr got %h want 0a000000", err_addr); end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL miss_clr_flag got %b want 0", err_flag); end
    endtask

    task automatic test_timeout;
        do_xfer(32'h0500_0020, 32'h0, 4'b0000, -1, 1'b1, 1'b0);
        checks++; if (lat !== 7) begin errors++; $display("FAIL timeout_latency got %0d want 7", lat); end
        checks++; if (widx !== 5) begin errors++; $display("FAIL timeout_wait_cycles got %0d want 5", widx); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_rdata got %h want deadbeef", rd); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL timeout_err_flag got %b want 1", err_flag); end
        checks++; if (err_addr !== 32'h0500_0020) begin errors++; $display("FAIL timeout_err_addr got %h want 05000020", err_addr); end
        @(negedge clk);
        checks++; if (s_valid !== 4'b0) begin errors++; $display("FAIL timeout_s_valid_drop got %b want 0", s_valid); end
        do_xfer(32'h0300_0040, 32'h0, 4'b0000, -1, 1'b0, 1'b0);
        checks++; if (err_addr !== 32'h0500_0020) begin errors++; $display("FAIL timeout2_err_addr got %h want 05000020", err_addr); end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL timeout_clr_flag got %b want 0", err_flag); end
    endtask

    task automatic test_clr_collision;
        do_xfer(32'h0B00_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        do_xfer(32'h0C00_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b1);
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL clr_race_flag got %b want 1", err_flag); end
        checks++; if (err_addr !== 32'h0C00_0000) begin errors++; $display("FAIL clr_race_addr got %h want 0c000000", err_addr); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0400_0000; mem_wstrb = 4'b0000;
        @(negedge clk);
        mem_valid = 1'b0;
        checks++; if (s_valid !== 4'b0010) begin errors++; $display("FAIL rst_wait_s_valid got %b want 0010", s_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (s_valid !== 4'b0) begin errors++; $display("FAIL rst_async_s_valid got %b want 0", s_valid); end
        checks++; if ({mem_ready, mem_rdata} !== 33'h0) begin errors++; $display("FAIL rst_async_mem got %b/%h want 0/0", mem_ready, mem_rdata); end
        checks++; if ({s_addr, s_wstrb} !== 36'h0) begin errors++; $display("FAIL rst_async_s_regs got %h/%b want 0/0", s_addr, s_wstrb); end
        checks++; if ({err_flag, err_addr} !== 33'h0) begin errors++; $display("FAIL rst_async_err got %b/%h want 0/0", err_flag, err_addr); end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_ready || (s_valid != '0)) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_spurious got %b want 0", seen); end
        do_xfer(32'h0500_0000, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
        checks++; if (rd !== 32'hC2C2_C2C2) begin errors++; $display("FAIL rst_recover_rdata got %h want c2c2c2c2", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rst_recover_latency got %0d want 3", lat); end
    endtask

    initial begin
        test_reset;
        test_read_hit;
        test_write;
        test_exact_zero;
        test_miss;
        test_timeout;
        test_clr_collision;
        test_reset_mid_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
